// File: rtl/aes_model_pack.sv
// Shared types and constants for the AES-128 CTR keystream path.
package aes_model_pack;

  localparam int unsigned KSG_CTR_W_DEFAULT = 32;
  localparam int unsigned AES_BLK_W         = 128;

  // 16-byte AES block, byte 15 in the most significant position
  typedef logic [15:0][7:0] byte_table;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_KEY  = 3'd1,
    S_LOAD_SYNC = 3'd2,
    S_KEY_VLD   = 3'd3,
    S_READY     = 3'd4,
    S_ENC       = 3'd5,
    S_BLK_VLD   = 3'd6
  } ksg_state_t;

endpackage

// File: rtl/avalon_st_if.sv
// Minimal Avalon-ST bundle with start/end-of-packet markers.
interface avalon_st_if #(
  parameter int unsigned DATA_W = 128
);
  logic [DATA_W-1:0] data;
  logic              vld;
  logic              rdy;
  logic              sop;
  logic              eop;

  modport source (output data, output vld, output sop, output eop, input rdy);
  modport sink   (input data, input vld, input sop, input eop, output rdy);
endinterface

// File: rtl/ctr_inc.sv
// Combinational CTR_W-bit incrementer; the all-ones value wraps to zero.
module ctr_inc #(
  parameter int unsigned CTR_W = 32
) (
  input  logic [CTR_W-1:0] ctr,
  output logic [CTR_W-1:0] ctr_inc_c
);

  // Modulo 2^CTR_W increment, no carry out
  always_comb begin
    ctr_inc_c = ctr + CTR_W'(1);
  end

endmodule

// File: rtl/keystream_gen_ctrl.sv
// Key/sync loader and CTR block sequencer in front of an external AES core.
module keystream_gen_ctrl
  import aes_model_pack::*;
#(
  parameter int unsigned CTR_W = KSG_CTR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_st_if.sink            cfg_st,
  input  logic                 key_and_sync_req,
  input  logic                 new_sync_req,
  output logic                 key_and_sync_vld,
  output logic                 cipher_block_vld,
  output byte_table            cipher_block,
  output logic                 aes_start,
  output logic [AES_BLK_W-1:0] aes_key,
  output logic [AES_BLK_W-1:0] aes_in_block,
  input  logic                 aes_done,
  input  logic [AES_BLK_W-1:0] aes_out_block,
  output logic                 seq_err
);

  ksg_state_t           state_q, state_d;
  logic [AES_BLK_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] sync_q, sync_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic [CTR_W-1:0]     ctr_nxt_c;
  byte_table            cipher_q, cipher_d;
  logic                 blk_pend_q, blk_pend_d;
  logic                 key_pend_q, key_pend_d;
  logic                 seq_err_q, seq_err_d;
  logic                 rdy_q, rdy_d;
  logic                 ksv_q, ksv_d;
  logic                 blk_vld_q, blk_vld_d;
  logic                 start_q, start_d;
  logic                 beat_c;
  logic                 blk_req_c;

  ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
    .ctr       (ctr_q),
    .ctr_inc_c (ctr_nxt_c)
  );

  assign beat_c           = cfg_st.vld & rdy_q;
  assign cfg_st.rdy       = rdy_q;
  assign key_and_sync_vld = ksv_q;
  assign cipher_block_vld = blk_vld_q;
  assign cipher_block     = cipher_q;
  assign aes_start        = start_q;
  assign aes_key          = key_q;
  assign aes_in_block     = {sync_q[AES_BLK_W-1:CTR_W], ctr_q};
  assign seq_err          = seq_err_q;

  // Block requests that arrive while busy are parked, one deep
  assign blk_req_c = new_sync_req &&
                     (state_q == S_LOAD_KEY || state_q == S_LOAD_SYNC ||
                      state_q == S_KEY_VLD  || state_q == S_ENC ||
                      state_q == S_BLK_VLD);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    sync_d     = sync_q;
    ctr_d      = ctr_q;
    cipher_d   = cipher_q;
    blk_pend_d = blk_pend_q;
    key_pend_d = key_pend_q;
    seq_err_d  = seq_err_q;

    if (aes_done && state_q != S_ENC) seq_err_d = 1'b1;

    if (blk_req_c) begin
      if (blk_pend_q) seq_err_d  = 1'b1;
      else            blk_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (new_sync_req)     seq_err_d = 1'b1;
        if (key_and_sync_req) state_d   = S_LOAD_KEY;
      end
      S_LOAD_KEY: begin
        if (beat_c) begin
          if (cfg_st.sop) begin
            key_d   = cfg_st.data;
            state_d = S_LOAD_SYNC;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      S_LOAD_SYNC: begin
        if (beat_c) begin
          if (cfg_st.eop) begin
            sync_d  = cfg_st.data;
            ctr_d   = cfg_st.data[CTR_W-1:0];
            state_d = S_KEY_VLD;
          end else if (cfg_st.sop) begin
            key_d = cfg_st.data;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      S_KEY_VLD: begin
        state_d = S_READY;
      end
      S_READY: begin
        if (key_and_sync_req) begin
          state_d = S_LOAD_KEY;
          if (new_sync_req) begin
            if (blk_pend_q) seq_err_d  = 1'b1;
            else            blk_pend_d = 1'b1;
          end
        end else if (new_sync_req || blk_pend_q) begin
          state_d    = S_ENC;
          blk_pend_d = 1'b0;
          if (new_sync_req && blk_pend_q) seq_err_d = 1'b1;
        end
      end
      S_ENC: begin
        if (key_and_sync_req) key_pend_d = 1'b1;
        if (aes_done) begin
          cipher_d = aes_out_block;
          state_d  = S_BLK_VLD;
        end
      end
      S_BLK_VLD: begin
        ctr_d = ctr_nxt_c;
        if (key_pend_q || key_and_sync_req) begin
          key_pend_d = 1'b0;
          state_d    = S_LOAD_KEY;
        end else begin
          state_d = S_READY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d     = (state_d == S_LOAD_KEY) || (state_d == S_LOAD_SYNC);
    ksv_d     = (state_d == S_KEY_VLD);
    blk_vld_d = (state_d == S_BLK_VLD);
    start_d   = (state_d == S_ENC) && (state_q != S_ENC);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      sync_q     <= '0;
      ctr_q      <= '0;
      cipher_q   <= '0;
      blk_pend_q <= 1'b0;
      key_pend_q <= 1'b0;
      seq_err_q  <= 1'b0;
      rdy_q      <= 1'b0;
      ksv_q      <= 1'b0;
      blk_vld_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      sync_q     <= sync_d;
      ctr_q      <= ctr_d;
      cipher_q   <= cipher_d;
      blk_pend_q <= blk_pend_d;
      key_pend_q <= key_pend_d;
      seq_err_q  <= seq_err_d;
      rdy_q      <= rdy_d;
      ksv_q      <= ksv_d;
      blk_vld_q  <= blk_vld_d;
      start_q    <= start_d;
    end
  end

endmodule

// File: tb/tb_keystream_gen_ctrl.sv
// Directed bench for keystream_gen_ctrl with hand-computed expectations.
module tb_keystream_gen_ctrl;
  import aes_model_pack::*;

  logic         clk;
  logic         rst;
  logic         key_and_sync_req;
  logic         new_sync_req;
  logic         key_and_sync_vld;
  logic         cipher_block_vld;
  byte_table    cipher_block;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_in_block;
  logic         aes_done;
  logic [127:0] aes_out_block;
  logic         seq_err;

  avalon_st_if #(.DATA_W(128)) cfg_st ();

  keystream_gen_ctrl #(.CTR_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_st           (cfg_st),
    .key_and_sync_req (key_and_sync_req),
    .new_sync_req     (new_sync_req),
    .key_and_sync_vld (key_and_sync_vld),
    .cipher_block_vld (cipher_block_vld),
    .cipher_block     (cipher_block),
    .aes_start        (aes_start),
    .aes_key          (aes_key),
    .aes_in_block     (aes_in_block),
    .aes_done         (aes_done),
    .aes_out_block    (aes_out_block),
    .seq_err          (seq_err)
  );

  localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SYNC1 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFE;
  localparam logic [127:0] KEY2  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] SYNC2 = 128'h11112222_33334444_55556666_00000010;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int n_blk = 0;
  int n_ksv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (aes_start)        n_start = n_start + 1;
    if (cipher_block_vld) n_blk   = n_blk + 1;
    if (key_and_sync_vld) n_ksv   = n_ksv + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b0;
    key_and_sync_req = 1'b0;
    new_sync_req     = 1'b0;
    aes_done         = 1'b0;
    aes_out_block    = '0;
    cfg_st.vld       = 1'b0;
    cfg_st.sop       = 1'b0;
    cfg_st.eop       = 1'b0;
    cfg_st.data      = '0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic put_beat(input logic [127:0] d, input logic s, input logic e);
    cfg_st.data = d;
    cfg_st.sop  = s;
    cfg_st.eop  = e;
    cfg_st.vld  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cfg_st.rdy) break;
      tick();
    end
    check("cfg_rdy_wait", 128'(cfg_st.rdy), 128'd1);
    tick();
    cfg_st.vld = 1'b0;
    cfg_st.sop = 1'b0;
    cfg_st.eop = 1'b0;
  endtask

  task automatic send_beats(input logic [127:0] k, input logic [127:0] s);
    int ksv0;
    ksv0 = n_ksv;
    put_beat(k, 1'b1, 1'b0);
    put_beat(s, 1'b0, 1'b1);
    check("ksv_latency", 128'(key_and_sync_vld), 128'd1);
    tick();
    check("ksv_one_pulse", 128'(n_ksv - ksv0), 128'd1);
    check("aes_key", aes_key, k);
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] s);
    key_and_sync_req = 1'b1;
    tick();
    key_and_sync_req = 1'b0;
    send_beats(k, s);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 10; i++) begin
      if (aes_start) break;
      tick();
    end
    check("start_seen", 128'(aes_start), 128'd1);
  endtask

  // Core answers after lat cycles; checks the block handshake end to end
  task automatic finish_block(input int lat, input logic [127:0] res, input logic [127:0] exp_in);
    int blk0;
    blk0 = n_blk;
    check("in_block_at_start", aes_in_block, exp_in);
    tick();
    check("start_one_cycle", 128'(aes_start), 128'd0);
    for (int i = 0; i < lat - 2; i++) tick();
    check("in_block_stable", aes_in_block, exp_in);
    aes_done      = 1'b1;
    aes_out_block = res;
    tick();
    aes_done = 1'b0;
    check("blk_vld_latency", 128'(cipher_block_vld), 128'd1);
    check("cipher_block", 128'(cipher_block), res);
    tick();
    check("blk_vld_one_pulse", 128'(n_blk - blk0), 128'd1);
    check("cipher_hold", 128'(cipher_block), res);
  endtask

  task automatic req_block(input int lat, input logic [127:0] res, input logic [127:0] exp_in);
    new_sync_req = 1'b1;
    tick();
    new_sync_req = 1'b0;
    check("start_latency", 128'(aes_start), 128'd1);
    finish_block(lat, res, exp_in);
  endtask

  initial begin
    int s0;
    int b0;
    do_reset();

    // Reset values
    check("rst_key", aes_key, '0);
    check("rst_in_block", aes_in_block, '0);
    check("rst_cipher", 128'(cipher_block), '0);
    check("rst_pulses", 128'({aes_start, cipher_block_vld, key_and_sync_vld}), 128'd0);
    check("rst_rdy_err", 128'({cfg_st.rdy, seq_err}), 128'd0);

    // Key load, three blocks across the counter wrap
    load_key(KEY1, SYNC1);
    check("no_err_after_load", 128'(seq_err), 128'd0);
    req_block(10, 128'h1234, SYNC1);
    check("ctr_inc_visible", aes_in_block, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF);
    req_block(3, 128'h5555, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF);
    req_block(4, 128'h6666, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000000);

    // Block and key requests both arrive mid-encryption
    new_sync_req = 1'b1;
    tick();
    new_sync_req = 1'b0;
    check("ovl_start", 128'(aes_start), 128'd1);
    check("ovl_in_block", aes_in_block, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000001);
    tick();
    new_sync_req     = 1'b1;
    key_and_sync_req = 1'b1;
    tick();
    new_sync_req     = 1'b0;
    key_and_sync_req = 1'b0;
    aes_done      = 1'b1;
    aes_out_block = 128'hBEEF;
    tick();
    aes_done = 1'b0;
    check("ovl_blk_vld", 128'(cipher_block_vld), 128'd1);
    check("ovl_cipher", 128'(cipher_block), 128'hBEEF);
    tick();
    check("ovl_goes_load", 128'(cfg_st.rdy), 128'd1);
    send_beats(KEY2, SYNC2);
    wait_start();
    check("ovl_new_key", aes_key, KEY2);
    finish_block(3, 128'h7777, SYNC2);
    check("ovl_no_err", 128'(seq_err), 128'd0);

    // new_sync_req with no key
    do_reset();
    s0 = n_start;
    new_sync_req = 1'b1;
    tick();
    new_sync_req = 1'b0;
    tick();
    tick();
    check("idle_req_err", 128'(seq_err), 128'd1);
    check("idle_req_no_start", 128'(n_start - s0), 128'd0);

    // Second block request while one is pending
    do_reset();
    key_and_sync_req = 1'b1;
    tick();
    key_and_sync_req = 1'b0;
    new_sync_req = 1'b1;
    tick();
    check("first_pend_ok", 128'(seq_err), 128'd0);
    tick();
    new_sync_req = 1'b0;
    check("second_pend_err", 128'(seq_err), 128'd1);
    s0 = n_start;
    send_beats(KEY1, SYNC1);
    wait_start();
    finish_block(3, 128'h9999, SYNC1);
    tick();
    tick();
    check("single_pend_start", 128'(n_start - s0), 128'd1);

    // Key beat without sop is dropped
    do_reset();
    key_and_sync_req = 1'b1;
    tick();
    key_and_sync_req = 1'b0;
    put_beat(128'hBAD0, 1'b0, 1'b0);
    check("nosop_err", 128'(seq_err), 128'd1);
    check("nosop_still_rdy", 128'(cfg_st.rdy), 128'd1);
    send_beats(KEY2, SYNC2);

    // Reset mid-encryption, then a stray aes_done
    new_sync_req = 1'b1;
    tick();
    new_sync_req = 1'b0;
    check("mid_enc_start", 128'(aes_start), 128'd1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_key", aes_key, '0);
    check("mid_rst_in_block", aes_in_block, '0);
    check("mid_rst_flags", 128'({aes_start, cipher_block_vld, key_and_sync_vld, cfg_st.rdy, seq_err}), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    b0 = n_blk;
    aes_done      = 1'b1;
    aes_out_block = 128'hFACE;
    tick();
    aes_done = 1'b0;
    tick();
    check("stray_done_no_vld", 128'(n_blk - b0), 128'd0);
    check("stray_done_cipher", 128'(cipher_block), '0);
    check("stray_done_err", 128'(seq_err), 128'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
